spike_count_classifier: RTL and testbench
=========================================

# spike_count_classifier

Parametrised output-layer spike counter and winner-take-all classifier for the SNN core. It keeps one saturating counter per output neuron over a timestep window. When the window closes, it scans the frozen counts sequentially to find the winning class, its count, and tie/no-spike flags. It sits between the neuron array's output spike vector and the result/UDP reporting logic, and adds a registered random-access count readout port.

## Interface
Parameters:
- N_NEURON, 10: number of output neurons/classes (2..256)
- CNT_W, 8: counter width; counters saturate at 2^CNT_W-1
- IDX_W, $clog2(N_NEURON): class index width

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RST_sync  in  1  synchronous, active-high reset
- spike_in  in  N_NEURON  per-neuron output spike, one cycle per event
- window_clr  in  1  clear all counters (start of new sample)
- window_end  in  1  level; high = window closed, counting frozen; rising edge starts a scan
- busy  out  1  scan in progress
- result_valid  out  1  one-cycle pulse, result fields updated
- result_idx  out  IDX_W  winning class
- result_max  out  CNT_W  winning count
- result_tie  out  1  another class equals result_max (result_max > 0)
- result_none  out  1  all counts zero
- result_margin  out  CNT_W  winner minus runner-up (see Configuration)
- rd_addr  in  IDX_W  readout address
- rd_data  out  CNT_W  count[rd_addr], registered

## Operation
- Counter i, evaluated in priority order per cycle:
  - RST_sync or window_clr: clear to 0.
  - Else spike_in[i] && !window_end && !busy && count[i] != 2^CNT_W-1: increment by 1.
  - Else hold. Counts never wrap.
- FSM states:
  - IDLE -> SCAN on window_end rising edge (window_end=1, previous sample 0); scan pointer p=0, best=0, best_idx=0, tie=0.
  - SCAN: one neuron per cycle.
    - count[p] > best: best=count[p], best_idx=p, tie=0.
    - count[p]==best && best>0: tie=1.
    - Strict compare, so the lowest index wins ties.
    - p==N_NEURON-1 -> DONE.
  - DONE: result registers loaded, result_valid=1 for this cycle -> IDLE.
- window_clr during SCAN or DONE: abort to IDLE, counters cleared, no result_valid, result registers keep old values.
- window_end held high re-triggers nothing; a new scan requires window_end to drop and rise again.
- window_end falling mid-scan: the scan completes normally. Counting stays frozen while busy.
- result_none = (best==0) at DONE; result_idx=0 in that case.
- rd_data = count[rd_addr] one cycle after rd_addr is sampled. rd_addr >= N_NEURON returns 0.

## Timing
- Reset values: busy=0, result_valid=0, result_idx=0, result_max=0, result_tie=0, result_none=1, result_margin=0, rd_data=0, all counts 0, FSM IDLE.
- Rising edge of window_end sampled at edge k:
  - busy=1 from k+1 through k+N_NEURON+1.
  - result_valid high for exactly the cycle after edge k+N_NEURON+1.
  - Total latency N_NEURON+1 cycles.
- Result fields change only together with result_valid and then hold.
- Readout latency 1 cycle, independent of FSM state.
- Spike arriving in the same cycle as window_clr is dropped. Spike in the same cycle window_end rises is dropped.

## Configuration
- SPIKE_CNT_MARGIN_EN defined:
  - FSM also tracks the runner-up count (largest among non-winners, including an equal tie value).
  - result_margin = result_max - runner_up, loaded at DONE. A tie gives 0.
- Not defined: no runner-up register is built, and result_margin is tied to 0.

## Test plan
- Reset then 3 spikes on neuron 4, 1 on neuron 7, window_end rise -> after N_NEURON+1 cycles result_valid pulse, idx=4, max=3, tie=0, none=0, margin=2 (MARGIN_EN).
- 300 spikes on neuron 2 with CNT_W=8 -> count holds 255; rd_addr=2 gives rd_data=255 next cycle.
- Neurons 3 and 6 each 5 spikes -> idx=3, max=5, tie=1, margin=0.
- No spikes, window_end rise -> idx=0, max=0, none=1, tie=0.
- window_clr pulsed 4 cycles into a scan -> busy drops next cycle, no result_valid, previous result held, all counts 0.
- Spikes driven while window_end=1 or busy=1 -> counts unchanged. window_end held high 50 cycles -> exactly one result_valid.

Source files
------------

// File: rtl/spike_count_classifier_if.sv
// rtl/spike_count_classifier_if.sv - spike counter/classifier signal bundle
// master drives spikes, window control and readout address; slave is the classifier.
interface spike_count_classifier_if #(
   parameter int N_NEURON = 10,
   parameter int CNT_W    = 8,
   parameter int IDX_W    = $clog2(N_NEURON)
);
   logic [N_NEURON-1:0] spike_in;
   logic                window_clr;
   logic                window_end;
   logic                busy;
   logic                result_valid;
   logic [IDX_W-1:0]    result_idx;
   logic [CNT_W-1:0]    result_max;
   logic                result_tie;
   logic                result_none;
   logic [CNT_W-1:0]    result_margin;
   logic [IDX_W-1:0]    rd_addr;
   logic [CNT_W-1:0]    rd_data;

   modport master (
      output spike_in, window_clr, window_end, rd_addr,
      input  busy, result_valid, result_idx, result_max, result_tie,
             result_none, result_margin, rd_data
   );

   modport slave (
      input  spike_in, window_clr, window_end, rd_addr,
      output busy, result_valid, result_idx, result_max, result_tie,
             result_none, result_margin, rd_data
   );
endinterface

// File: rtl/spike_count_classifier.sv
// rtl/spike_count_classifier.sv - per-neuron spike counters with sequential winner-take-all scan
// Optional runner-up/margin tracking is built when SPIKE_CNT_MARGIN_EN is defined.
module spike_count_classifier #(
   parameter int N_NEURON = 10,
   parameter int CNT_W    = 8,
   parameter int IDX_W    = $clog2(N_NEURON)
) (
   input  logic CLK,
   input  logic RST_sync,
   spike_count_classifier_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q [N_NEURON];
   logic [CNT_W-1:0] cnt_d [N_NEURON];
   logic             we_prev_q, we_prev_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0] best_q, best_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             tie_q, tie_d;
   logic             res_valid_q, res_valid_d;
   logic [IDX_W-1:0] res_idx_q, res_idx_d;
   logic [CNT_W-1:0] res_max_q, res_max_d;
   logic             res_tie_q, res_tie_d;
   logic             res_none_q, res_none_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic [CNT_W-1:0] cur;
   logic             busy;
   logic             we_rise;
`ifdef SPIKE_CNT_MARGIN_EN
   logic [CNT_W-1:0] runner_q, runner_d;
   logic [CNT_W-1:0] res_margin_q, res_margin_d;
`endif

   assign busy      = (state_q != S_IDLE);
   assign we_rise   = bus.window_end & ~we_prev_q;
   assign we_prev_d = bus.window_end;

   always_comb begin
      for (int i = 0; i < N_NEURON; i++) begin
         cnt_d[i] = cnt_q[i];
         if (bus.window_clr)
            cnt_d[i] = '0;
         else if (bus.spike_in[i] && !bus.window_end && !busy && cnt_q[i] != CNT_MAX)
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
   end

   // Mux-by-compare keeps out-of-range addresses reading as zero without indexing past the array.
   always_comb begin
      cur       = '0;
      rd_data_d = '0;
      for (int i = 0; i < N_NEURON; i++) begin
         if (ptr_q == IDX_W'(i))       cur       = cnt_q[i];
         if (bus.rd_addr == IDX_W'(i)) rd_data_d = cnt_q[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      best_d      = best_q;
      best_idx_d  = best_idx_q;
      tie_d       = tie_q;
      res_valid_d = 1'b0;
      res_idx_d   = res_idx_q;
      res_max_d   = res_max_q;
      res_tie_d   = res_tie_q;
      res_none_d  = res_none_q;
`ifdef SPIKE_CNT_MARGIN_EN
      runner_d     = runner_q;
      res_margin_d = res_margin_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (we_rise) begin
               state_d    = S_SCAN;
               ptr_d      = '0;
               best_d     = '0;
               best_idx_d = '0;
               tie_d      = 1'b0;
`ifdef SPIKE_CNT_MARGIN_EN
               runner_d   = '0;
`endif
            end
         end
         S_SCAN: begin
            // Strict greater-than keeps the lowest index as winner on ties.
            if (cur > best_q) begin
               best_d     = cur;
               best_idx_d = ptr_q;
               tie_d      = 1'b0;
            end else if (cur == best_q && best_q != '0) begin
               tie_d      = 1'b1;
            end
`ifdef SPIKE_CNT_MARGIN_EN
            if (cur > best_q)
               runner_d = best_q;
            else if (cur > runner_q)
               runner_d = cur;
`endif
            if (ptr_q == IDX_W'(N_NEURON-1))
               state_d = S_DONE;
            else
               ptr_d = ptr_q + IDX_W'(1);
         end
         S_DONE: begin
            res_valid_d = 1'b1;
            res_idx_d   = best_idx_q;
            res_max_d   = best_q;
            res_tie_d   = tie_q;
            res_none_d  = (best_q == '0);
`ifdef SPIKE_CNT_MARGIN_EN
            res_margin_d = best_q - runner_q;
`endif
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Clearing the window abandons any scan and leaves the last result untouched.
      if (bus.window_clr) begin
         state_d     = S_IDLE;
         res_valid_d = 1'b0;
         res_idx_d   = res_idx_q;
         res_max_d   = res_max_q;
         res_tie_d   = res_tie_q;
         res_none_d  = res_none_q;
`ifdef SPIKE_CNT_MARGIN_EN
         res_margin_d = res_margin_q;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RST_sync) begin
         state_q     <= S_IDLE;
         for (int i = 0; i < N_NEURON; i++) cnt_q[i] <= '0;
         we_prev_q   <= 1'b0;
         ptr_q       <= '0;
         best_q      <= '0;
         best_idx_q  <= '0;
         tie_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_idx_q   <= '0;
         res_max_q   <= '0;
         res_tie_q   <= 1'b0;
         res_none_q  <= 1'b1;
         rd_data_q   <= '0;
`ifdef SPIKE_CNT_MARGIN_EN
         runner_q     <= '0;
         res_margin_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         for (int i = 0; i < N_NEURON; i++) cnt_q[i] <= cnt_d[i];
         we_prev_q   <= we_prev_d;
         ptr_q       <= ptr_d;
         best_q      <= best_d;
         best_idx_q  <= best_idx_d;
         tie_q       <= tie_d;
         res_valid_q <= res_valid_d;
         res_idx_q   <= res_idx_d;
         res_max_q   <= res_max_d;
         res_tie_q   <= res_tie_d;
         res_none_q  <= res_none_d;
         rd_data_q   <= rd_data_d;
`ifdef SPIKE_CNT_MARGIN_EN
         runner_q     <= runner_d;
         res_margin_q <= res_margin_d;
`endif
      end
   end

   assign bus.busy         = busy;
   assign bus.result_valid = res_valid_q;
   assign bus.result_idx   = res_idx_q;
   assign bus.result_max   = res_max_q;
   assign bus.result_tie   = res_tie_q;
   assign bus.result_none  = res_none_q;
   assign bus.rd_data      = rd_data_q;
`ifdef SPIKE_CNT_MARGIN_EN
   assign bus.result_margin = res_margin_q;
`else
   assign bus.result_margin = '0;
`endif
endmodule

// File: tb/tb_spike_count_classifier.sv
// tb/tb_spike_count_classifier.sv - scoreboard bench for spike_count_classifier
module tb_spike_count_classifier;
   localparam int N    = 10;
   localparam int W    = 8;
   localparam int IW   = 4;
   localparam int MAXC = 255;

   typedef struct {
      logic [IW-1:0] idx;
      logic [W-1:0]  max;
      logic          tie;
      logic          none;
      logic [W-1:0]  margin;
   } res_t;

   logic CLK = 1'b0;
   logic RST_sync = 1'b1;

   spike_count_classifier_if #(.N_NEURON(N), .CNT_W(W), .IDX_W(IW)) bus ();

   spike_count_classifier #(.N_NEURON(N), .CNT_W(W), .IDX_W(IW)) dut (
      .CLK      (CLK),
      .RST_sync (RST_sync),
      .bus      (bus)
   );

   always #5 CLK = ~CLK;

   int   model [N];
   res_t sb [$];
   res_t last_res;
   int   vectors = 0;
   int   miscompares = 0;

   function automatic res_t model_result();
      res_t r;
      int best = 0, bi = 0, run = 0;
      bit t = 1'b0;
      for (int i = 0; i < N; i++)
         if (model[i] > best) begin best = model[i]; bi = i; end
      for (int i = 0; i < N; i++)
         if (i != bi) begin
            if (model[i] > run) run = model[i];
            if (model[i] == best && best > 0) t = 1'b1;
         end
      r.idx  = IW'(bi);
      r.max  = W'(best);
      r.tie  = t;
      r.none = (best == 0);
`ifdef SPIKE_CNT_MARGIN_EN
      r.margin = W'(best - run);
`else
      r.margin = '0;
`endif
      return r;
   endfunction

   task automatic clear_window();
      @(negedge CLK);
      bus.window_clr = 1'b1;
      bus.spike_in   = '1;
      @(negedge CLK);
      bus.window_clr = 1'b0;
      bus.spike_in   = '0;
      for (int i = 0; i < N; i++) model[i] = 0;
   endtask

   task automatic spike_burst(input int idx, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         bus.spike_in = '0;
         bus.spike_in[idx] = 1'b1;
         if (model[idx] < MAXC) model[idx]++;
      end
      @(negedge CLK);
      bus.spike_in = '0;
   endtask

   task automatic spike_vec(input logic [N-1:0] vec);
      @(negedge CLK);
      bus.spike_in = vec;
      for (int i = 0; i < N; i++)
         if (vec[i] && model[i] < MAXC) model[i]++;
      @(negedge CLK);
      bus.spike_in = '0;
   endtask

   task automatic read_check(input int addr, input int exp);
      @(negedge CLK);
      bus.rd_addr = IW'(addr);
      @(negedge CLK);
      vectors++;
      if (bus.rd_data !== W'(exp)) begin
         miscompares++;
         $display("FAIL rd_data[%0d]: got %0d expected %0d", addr, bus.rd_data, exp);
      end
   endtask

   task automatic check_counts();
      for (int i = 0; i < N; i++) read_check(i, model[i]);
   endtask

   task automatic check_result_fields(input res_t e, input string tag);
      vectors++;
      if (bus.result_idx !== e.idx || bus.result_max !== e.max || bus.result_tie !== e.tie ||
          bus.result_none !== e.none || bus.result_margin !== e.margin) begin
         miscompares++;
         $display("FAIL %s: got idx=%0d max=%0d tie=%0d none=%0d margin=%0d expected idx=%0d max=%0d tie=%0d none=%0d margin=%0d",
                  tag, bus.result_idx, bus.result_max, bus.result_tie, bus.result_none, bus.result_margin,
                  e.idx, e.max, e.tie, e.none, e.margin);
      end
   endtask

   // Rising window_end, spikes on the rise cycle and during busy must all be ignored.
   task automatic run_scan(input int hold, input bit drop_mid);
      res_t exp;
      logic [N-1:0] rnd;
      int extra_valid = 0;
      exp = model_result();
      sb.push_back(exp);
      @(negedge CLK);
      bus.window_end = 1'b1;
      bus.spike_in   = '1;
      for (int j = 0; j < N + 4; j++) begin
         @(negedge CLK);
         rnd = N'($urandom);
         bus.spike_in = (j < N) ? rnd : '0;
         if (drop_mid && j == 2) bus.window_end = 1'b0;
         vectors++;
         if (bus.busy !== (j <= N)) begin
            miscompares++;
            $display("FAIL busy@%0d: got %0b expected %0b", j, bus.busy, (j <= N));
         end
         vectors++;
         if (bus.result_valid !== (j == N + 1)) begin
            miscompares++;
            $display("FAIL result_valid@%0d: got %0b expected %0b", j, bus.result_valid, (j == N + 1));
         end
         if (bus.result_valid === 1'b1) begin
            if (sb.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL sb_empty: got valid expected none");
            end else begin
               last_res = sb.pop_front();
               check_result_fields(last_res, "result");
            end
         end
      end
      check_result_fields(last_res, "result_hold");
      for (int h = 0; h < hold; h++) begin
         @(negedge CLK);
         rnd = N'($urandom);
         bus.spike_in = rnd;
         if (bus.result_valid === 1'b1) extra_valid++;
      end
      @(negedge CLK);
      bus.spike_in   = '0;
      bus.window_end = 1'b0;
      vectors++;
      if (extra_valid != 0 || sb.size() != 0) begin
         miscompares++;
         $display("FAIL extra_valid: got %0d extra / %0d pending expected 0 / 0", extra_valid, sb.size());
      end
      sb.delete();
   endtask

   task automatic test_reset();
      res_t e;
      e.idx = '0; e.max = '0; e.tie = 1'b0; e.none = 1'b1; e.margin = '0;
      RST_sync = 1'b1;
      repeat (3) @(negedge CLK);
      vectors++;
      if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0 || bus.rd_data !== '0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got busy=%0b valid=%0b rd=%0d expected 0 0 0", bus.busy, bus.result_valid, bus.rd_data);
      end
      check_result_fields(e, "reset_result");
      RST_sync = 1'b0;
      spike_burst(0, 3);
      read_check(0, 3);
      @(negedge CLK);
      RST_sync = 1'b1;
      @(negedge CLK);
      RST_sync = 1'b0;
      for (int i = 0; i < N; i++) model[i] = 0;
      read_check(0, 0);
      last_res = e;
   endtask

   task automatic test_basic();
      clear_window();
      spike_burst(4, 3);
      spike_burst(7, 1);
      run_scan(0, 1'b0);
      check_counts();
   endtask

   task automatic test_saturation();
      clear_window();
      spike_burst(2, 300);
      read_check(2, MAXC);
      read_check(3, 0);
      read_check(12, 0);
      read_check(15, 0);
      run_scan(0, 1'b0);
   endtask

   task automatic test_tie();
      clear_window();
      spike_burst(3, 5);
      spike_burst(6, 5);
      spike_burst(9, 2);
      run_scan(0, 1'b0);
   endtask

   task automatic test_none();
      clear_window();
      run_scan(0, 1'b0);
   endtask

   task automatic test_abort();
      res_t held;
      clear_window();
      spike_burst(1, 2);
      run_scan(0, 1'b0);
      held = last_res;
      spike_burst(5, 3);
      @(negedge CLK);
      bus.window_end = 1'b1;
      repeat (4) @(negedge CLK);
      bus.window_clr = 1'b1;
      @(negedge CLK);
      bus.window_clr = 1'b0;
      for (int i = 0; i < N; i++) model[i] = 0;
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_busy: got %0b expected 0", bus.busy);
      end
      for (int j = 0; j < 15; j++) begin
         @(negedge CLK);
         vectors++;
         if (bus.result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_valid@%0d: got %0b expected 0", j, bus.result_valid);
         end
      end
      check_result_fields(held, "abort_held");
      bus.window_end = 1'b0;
      check_counts();
   endtask

   task automatic test_frozen();
      clear_window();
      spike_burst(8, 2);
      spike_burst(0, 1);
      run_scan(50, 1'b0);
      check_counts();
      run_scan(0, 1'b1);
      check_counts();
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] v;
      for (int r = 0; r < 3; r++) begin
         clear_window();
         for (int c = 0; c < 6; c++) begin
            v = N'($urandom);
            spike_vec(v);
         end
         run_scan(0, 1'b0);
      end
      check_counts();
   endtask

   initial begin
      bus.spike_in   = '0;
      bus.window_clr = 1'b0;
      bus.window_end = 1'b0;
      bus.rd_addr    = '0;
      for (int i = 0; i < N; i++) model[i] = 0;
      test_reset();
      test_basic();
      test_saturation();
      test_tie();
      test_none();
      test_abort();
      test_frozen();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
